calc_result_tx: RTL and testbench

CALC_RESULT_TX -- requirements
Module: calc_result_tx

---
 rtl/calc_result_tx.sv | 194 +++++++++++++++++++
 tb/tb_calc_result_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/calc_result_tx.sv
// -----------------------------------------------------------------------------
// calc_result_tx
//
// Takes one single-digit arithmetic command (operand1 <op> operand2), computes
// the signed result and streams it as ASCII bytes to a UART transmitter:
//   optional '-', optional tens digit, ones digit, optional CR LF.
// Errors (divide by zero, unknown operator, operand > 9) send ERR_CHAR instead
// of the number.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   operand1   first operand, binary 0..9
//   operand2   second operand, binary 0..9
//   operator   ASCII operator: '+', '-', '*', '/'
//   cmd_valid  one-cycle command strobe
//   tx_ready   downstream transmitter can take a byte
//   tx_data    byte to send, valid while tx_start is high
//   tx_start   one-cycle request to send tx_data
//   busy       a command is being computed or sent
//   err        one-cycle pulse in the cycle an error result is computed
//   cmd_drop   one-cycle pulse when cmd_valid arrives while busy
//
// Handshake: a byte is transferred in any cycle where the block is in SEND and
// tx_ready is high; tx_start is raised combinationally in that same cycle with
// tx_data already stable. The following HOLD cycle ignores tx_ready so the
// transmitter has time to drop it.
// -----------------------------------------------------------------------------
module calc_result_tx #(
  parameter bit         EOL_CRLF = 1'b1,
  parameter logic [7:0] ERR_CHAR = 8'h45
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] operand1,
  input  logic [7:0] operand2,
  input  logic [7:0] operator,
  input  logic       cmd_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       err,
  output logic       cmd_drop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t     state_q;
  logic [7:0] op1_q;
  logic [7:0] op2_q;
  logic [7:0] opc_q;
  logic [7:0] buf_q [5];
  logic [2:0] cnt_q;   // number of bytes in the response
  logic [2:0] idx_q;   // index of the next byte to send

  // ---------------------------------------------------------------------------
  // Arithmetic on the captured command. Result is sign + 7-bit magnitude; with
  // legal operands the magnitude never exceeds 81.
  // ---------------------------------------------------------------------------
  logic       calc_err;
  logic       res_neg;
  logic [6:0] res_mag;
  logic [7:0] prod;
  logic [7:0] den;
  logic [7:0] quot;
  logic [6:0] tens;
  logic [6:0] ones;

  assign prod = {4'd0, op1_q[3:0]} * {4'd0, op2_q[3:0]};
  // The divisor is forced to 1 on zero so the divider never sees 0; the error
  // path discards the quotient in that case anyway.
  assign den  = (op2_q == 8'd0) ? 8'd1 : op2_q;
  assign quot = op1_q / den;

  always_comb begin
    calc_err = 1'b0;
    res_neg  = 1'b0;
    res_mag  = 7'd0;
    case (opc_q)
      8'h2B: res_mag = op1_q[6:0] + op2_q[6:0];
      8'h2D: begin
        if (op1_q >= op2_q) begin
          res_mag = op1_q[6:0] - op2_q[6:0];
        end else begin
          res_neg = 1'b1;
          res_mag = op2_q[6:0] - op1_q[6:0];
        end
      end
      8'h2A: res_mag = prod[6:0];
      8'h2F: begin
        if (op2_q == 8'd0) calc_err = 1'b1;
        else               res_mag  = quot[6:0];
      end
      default: calc_err = 1'b1;
    endcase
    if ((op1_q > 8'd9) || (op2_q > 8'd9)) calc_err = 1'b1;
    if (calc_err) begin
      res_neg = 1'b0;
      res_mag = 7'd0;
    end
  end

  assign tens = res_mag / 7'd10;
  assign ones = res_mag % 7'd10;

  // ---------------------------------------------------------------------------
  // Response byte list, packed from index 0. A negative result is at most -9,
  // so sign and tens digit never both appear: the list is at most 4 bytes.
  // ---------------------------------------------------------------------------
  logic [7:0] nb [5];
  logic [2:0] nn;

  always_comb begin
    for (int i = 0; i < 5; i++) nb[i] = 8'h00;
    nn = 3'd0;
    if (calc_err) begin
      nb[0] = ERR_CHAR;
      nn    = 3'd1;
    end else begin
      if (res_neg) begin
        nb[nn] = 8'h2D;
        nn     = nn + 3'd1;
      end
      if (res_mag >= 7'd10) begin
        nb[nn] = 8'h30 + {1'b0, tens};
        nn     = nn + 3'd1;
      end
      nb[nn] = 8'h30 + {1'b0, ones};
      nn     = nn + 3'd1;
    end
    if (EOL_CRLF) begin
      nb[nn]        = 8'h0D;
      nb[nn + 3'd1] = 8'h0A;
      nn            = nn + 3'd2;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op1_q   <= 8'h00;
      op2_q   <= 8'h00;
      opc_q   <= 8'h00;
      cnt_q   <= 3'd0;
      idx_q   <= 3'd0;
      for (int i = 0; i < 5; i++) buf_q[i] <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op1_q   <= operand1;
            op2_q   <= operand2;
            opc_q   <= operator;
            state_q <= CALC;
          end
        end
        CALC: begin
          for (int i = 0; i < 5; i++) buf_q[i] <= nb[i];
          cnt_q   <= nn;
          idx_q   <= 3'd0;
          state_q <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            idx_q   <= idx_q + 3'd1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (idx_q < cnt_q) state_q <= SEND;
          else               state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state; all are 0 while reset holds IDLE.
  assign busy     = (state_q != IDLE);
  assign tx_start = (state_q == SEND) && tx_ready;
  assign tx_data  = (state_q == SEND) ? buf_q[idx_q] : 8'h00;
  assign err      = (state_q == CALC) && calc_err;
  assign cmd_drop = cmd_valid && busy;

endmodule

// File: tb/tb_calc_result_tx.sv
module tb_calc_result_tx;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] operand1 = 8'h00;
  logic [7:0] operand2 = 8'h00;
  logic [7:0] operator = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       err;
  logic       cmd_drop;

  always #5 clk = ~clk;

  calc_result_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .operand1 (operand1),
    .operand2 (operand2),
    .operator (operator),
    .cmd_valid(cmd_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy),
    .err      (err),
    .cmd_drop (cmd_drop)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (tx_start) got_q.push_back(tx_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_bytes(input logic [31:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(b[i*8 +: 8]);
  endtask

  // ---------------- driver tasks ----------------
  // Issues a command, checks acceptance, the CALC cycle and (with tx_ready
  // high) the first tx_start two cycles after cmd_valid.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] opc,
                         input logic [7:0] b, input logic exp_err);
    got_q.delete();
    @(posedge clk); #1;
    operand1 = a; operand2 = b; operator = opc; cmd_valid = 1'b1;
    @(negedge clk);
    check("accept_busy", busy, 0);
    check("accept_drop", cmd_drop, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // scramble inputs: captured command must be unaffected
    operand1 = 8'($urandom_range(0, 255));
    operand2 = 8'($urandom_range(0, 255));
    operator = 8'($urandom_range(0, 255));
    @(negedge clk);
    check("calc_busy", busy, 1);
    check("calc_err", err, exp_err);
    check("calc_txs", tx_start, 0);
    if (tx_ready) begin
      @(negedge clk);
      check("first_tx_lat", tx_start, 1);
    end
  endtask

  // Waits for the block to go idle, then compares the sent bytes.
  task automatic finish_cmd();
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", (k < 100), 1);
    check("byte_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("byte", got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    int k;
    // reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", {tx_data, tx_start, busy, err, cmd_drop}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 3+4: latency checked inside run_cmd; busy low after last HOLD
    exp_bytes(32'h00370D0A, 3);
    run_cmd(8'd3, 8'h2B, 8'd4, 1'b0);
    repeat (5) @(negedge clk);
    check("busy_last_hold", busy, 1);   // cycle N+7 is the last HOLD
    @(negedge clk);
    check("busy_idle", busy, 0);
    finish_cmd();

    exp_bytes(32'h38310D0A, 4); run_cmd(8'd9, 8'h2A, 8'd9, 1'b0); finish_cmd();
    exp_bytes(32'h2D350D0A, 4); run_cmd(8'd2, 8'h2D, 8'd7, 1'b0); finish_cmd();
    exp_bytes(32'h00450D0A, 3); run_cmd(8'd5, 8'h2F, 8'd0, 1'b1); finish_cmd();
    exp_bytes(32'h00330D0A, 3); run_cmd(8'd7, 8'h2F, 8'd2, 1'b0); finish_cmd();
    exp_bytes(32'h00450D0A, 3); run_cmd(8'd1, 8'h3F, 8'd1, 1'b1); finish_cmd();
    exp_bytes(32'h00300D0A, 3); run_cmd(8'd4, 8'h2D, 8'd4, 1'b0); finish_cmd();
    exp_bytes(32'h00450D0A, 3); run_cmd(8'd10, 8'h2B, 8'd1, 1'b1); finish_cmd();
    exp_bytes(32'h31300D0A, 4); run_cmd(8'd5, 8'h2A, 8'd2, 1'b0); finish_cmd();

    // back-pressure: 20 cycles of tx_ready=0 in SEND
    tx_ready = 1'b0;
    exp_bytes(32'h38310D0A, 4);
    run_cmd(8'd9, 8'h2A, 8'd9, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || tx_data !== 8'h38 || busy !== 1'b1) bad++;
    end
    check("stall_stable", bad, 0);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk);
    check("stall_release", {tx_start, tx_data}, {1'b1, 8'h38});
    finish_cmd();

    // command while busy is dropped
    exp_bytes(32'h00370D0A, 3);
    run_cmd(8'd3, 8'h2B, 8'd4, 1'b0);
    @(posedge clk); #1;
    operand1 = 8'd1; operand2 = 8'd1; operator = 8'h2B; cmd_valid = 1'b1;
    @(negedge clk);
    check("drop_pulse", cmd_drop, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("drop_one_cycle", cmd_drop, 0);
    finish_cmd();
    repeat (10) @(negedge clk);
    check("no_second_resp", got_q.size(), 0);
    got_q.delete();

    // reset after the 2nd byte of "81\r\n"
    run_cmd(8'd9, 8'h2A, 8'd9, 1'b0);
    k = 0;
    while (got_q.size() < 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("second_byte_seen", got_q.size(), 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {tx_data, tx_start, busy, err, cmd_drop}, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_abort", got_q.size(), 2);
    check("rst_idle", busy, 0);
    got_q.delete();
    exp_bytes(32'h00320D0A, 3); run_cmd(8'd1, 8'h2B, 8'd1, 1'b0); finish_cmd();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
